// File: rtl/sel_mux_pkg.sv
// Shared constants for the registered operand selector.
// Mode encodings only; widths live on the modules.
package sel_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Search starts one past ptr and wraps modulo NUM_IN.
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt,
  output logic              gnt_vld
);

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    // Walk farthest-first so the nearest requester wins last.
    for (int k = NUM_IN; k >= 1; k--) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (j == (int'(ptr) + k) % NUM_IN && req[j]) begin
          gnt     = SEL_W'(j);
          gnt_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sel_mux_rr.sv
// Registered N:1 operand selector, fixed or round-robin,
// with valid/ready on every input and on the output.
module sel_mux_rr
  import sel_mux_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PAD = 2**SEL_W;
  localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_IN);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] rrGnt;
  logic             rrVld;
  logic             fixVld;
  logic             gntVld;
  logic             load;
  logic [PAD-1:0]   validPad;
  logic [WIDTH-1:0] gntData;

  assign load     = !out_valid || out_ready;
  assign validPad = PAD'(in_valid);
  // Padding bits are zero, but keep the range check explicit.
  assign fixVld   = ({1'b0, sel} < NUM_L) && validPad[sel];

  rr_arbiter #(
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) uArb (
    .req    (in_valid),
    .ptr    (ptr),
    .gnt    (rrGnt),
    .gnt_vld(rrVld)
  );

  always_comb begin
    gnt    = sel;
    gntVld = fixVld;
    if (mode == MODE_RR) begin
      gnt    = rrGnt;
      gntVld = rrVld;
    end
  end

  always_comb begin
    gntData = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt == SEL_W'(i)) gntData = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = load && gntVld && (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= gntVld;
      if (gntVld) begin
        out_data <= gntData;
        out_src  <= gnt;
      end
    end
  end

  // Only round-robin transfers move the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SEL_W'(NUM_IN - 1);
    end else if (load && gntVld && mode == MODE_RR) begin
      ptr <= gnt;
    end
  end

endmodule

// File: doc/sel_mux_rr.md
# sel_mux_rr

Parametrised, registered N-to-1 operand selector with per-channel valid/ready handshake and two selection modes: externally steered (fixed select) and round-robin arbitration. Generalises the ALU's registered 4:1 6-bit operand mux to arbitrary width and channel count and adds flow control, so upstream operand sources and the downstream ALU stage can stall independently. One output register stage; sits between operand sources and the ALU input.

## Interface
- `WIDTH`, 6: data width per channel.
- `NUM_IN`, 4: number of input channels, 2..16.
- `SEL_W`, `$clog2(NUM_IN)`: select/index width (derived; do not override).

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock, async assert, logic released on `clk` edge.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SEL_W  channel index used in fixed mode.
- `in_data`  in  NUM_IN*WIDTH  flattened inputs; channel i at bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NUM_IN  per-channel valid.
- `in_ready`  out  NUM_IN  per-channel accept, one-hot or zero; combinational.
- `out_data`  out  WIDTH  registered selected data.
- `out_src`  out  SEL_W  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  downstream accept.

## Operation
- Output register is a single entry. `load = !out_valid || out_ready`.
- Grant logic (combinational):
  - Fixed mode: `gnt_vld = (sel < NUM_IN) && in_valid[sel]`, `gnt = sel`. An out-of-range `sel` grants nothing.
  - RR mode: search channels `ptr+1, ptr+2, …` modulo NUM_IN. The first channel with `in_valid` set is granted. `gnt_vld = |in_valid`.
- Handshake:
  - `in_ready[i] = load && gnt_vld && (gnt == i)`. At most one bit is high.
  - A transfer occurs on input i when `in_valid[i] && in_ready[i]`.
- On a clock edge with `load`:
  - `out_valid <= gnt_vld`.
  - If `gnt_vld`: `out_data <= granted data`, `out_src <= gnt`.
  - If `!gnt_vld`: `out_data` and `out_src` hold their values.
- On a clock edge with `!load` (stall): all outputs hold.
- Round-robin pointer:
  - Updated to `gnt` only on an RR-mode transfer.
  - Fixed-mode transfers leave it unchanged.
  - Switching modes never resets it.
- `mode` and `sel` are sampled every cycle and take effect in the same cycle's grant. No lock across cycles.
- Ungranted channels hold their data. The block never drops or duplicates a beat.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `ptr=NUM_IN-1`, so the first RR search starts at channel 0.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Simultaneous `out_ready` and new grant: the old beat leaves and the new beat loads on the same edge. No bubble.
- Full (`out_valid && !out_ready`): all `in_ready` are 0.
- Empty, no valid inputs: `out_valid` falls to 0 after the current beat is accepted.
- RR wrap-around: when `ptr=NUM_IN-1`, the search begins at channel 0.
- Reset asserted mid-transfer: the beat is discarded and outputs go to reset values immediately (async). No transfer completes on the release edge unless `load` and `gnt_vld` are true on that edge.

## Structure
- Shared package `sel_mux_pkg`:
  - mode constants `MODE_FIXED=1'b0`, `MODE_RR=1'b1`.
  - no other typedefs.
- Sub-module `rr_arbiter` (params `NUM_IN`).
  - Inputs: `req`, `ptr`. Outputs: `gnt`, `gnt_vld`.
  - Purely combinational priority rotate.
  - Pointer register stays in the top level.
- Top level holds the output register, the pointer register, fixed/RR grant select, and `in_ready` decode.

## Test plan
- Reset, then fixed mode, `sel=2`, `in_valid=4'b0100`, `in_data[2]=6'h2A`, `out_ready=1`. Expect `in_ready=4'b0100` and, next cycle, `out_valid=1`, `out_data=6'h2A`, `out_src=2`.
- RR mode, all four valid, `out_ready=1`. Expect grants 0,1,2,3,0 on consecutive cycles, one beat per cycle.
- RR, all valid; hold `out_ready=0` for 3 cycles, then release. Expect `in_ready=0` and outputs stable during the stall, and the first beat kept. The pointer advances by exactly one per accepted beat.
- RR, `in_valid=4'b1000`, `ptr=3` after a channel-3 grant, then `in_valid=4'b1001`. Expect wrap-around grant to channel 0 before channel 3.
- Fixed mode, `sel=1`, `in_valid[1]=0`, other channels valid. Expect no grant, `out_valid=0`. Switch `mode=1` in the next cycle: expect the RR grant that cycle, with the pointer unchanged by the fixed-mode phase.
- With `NUM_IN=3`, `WIDTH=16`: fixed `sel=3` grants nothing. Assert `rst_n=0` mid-stream: expect outputs to reach reset values without waiting for a clock edge, and RR to restart at channel 0.
